// File: rtl/ramctrl_pkg.sv
// Shared constants, width codes and FSM state type
// for the byte-serialising RAM/IO controller.
package ramctrl_pkg;

  localparam int AddressWidth = 32;
  localparam int IDWidth      = 32;
  localparam logic [31:0] IOBase = 32'h0003_0000;

  localparam logic [2:0] WIDTH_B = 3'd1;
  localparam logic [2:0] WIDTH_H = 3'd2;
  localparam logic [2:0] WIDTH_W = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_IOSTALL
  } state_e;

  // Any width code other than byte/half is a word.
  function automatic logic [2:0] width_n(input logic [2:0] w);
    case (w)
      WIDTH_B: return WIDTH_B;
      WIDTH_H: return WIDTH_H;
      default: return WIDTH_W;
    endcase
  endfunction

  function automatic logic is_io(input logic [1:0] a_hi);
    return a_hi == IOBase[17:16];
  endfunction

endpackage

// File: rtl/ramctrl_sext.sv
// Sign/zero extension of an assembled read word
// according to its byte count.
module ramctrl_sext
  import ramctrl_pkg::*;
(
  input  logic [IDWidth-1:0] word_i,
  input  logic [2:0]         n_i,
  input  logic               sgn_i,
  output logic [IDWidth-1:0] word_o
);

  // Extend from bit 7 or bit 15; words pass through.
  always_comb begin
    word_o = word_i;
    if (n_i == WIDTH_B) begin
      word_o[IDWidth-1:8] = {(IDWidth-8){sgn_i & word_i[7]}};
    end else if (n_i == WIDTH_H) begin
      word_o[IDWidth-1:16] = {(IDWidth-16){sgn_i & word_i[15]}};
    end
  end

endmodule

// File: rtl/ramctrl.sv
// Data/fetch responder serialising requests into
// byte accesses on the 8-bit RAM/IO bus.
module ramctrl
  import ramctrl_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    datactrl_ramctrl_data_en_in,
  input  logic                    datactrl_ramctrl_data_rw_in,
  input  logic                    datactrl_ramctrl_data_sgn_in,
  input  logic [2:0]              datactrl_ramctrl_data_width_in,
  input  logic [AddressWidth-1:0] datactrl_ramctrl_data_addr_in,
  input  logic [IDWidth-1:0]      datactrl_ramctrl_data_data_in,
  output logic                    ramctrl_datactrl_data_rdy_out,
  output logic [IDWidth-1:0]      ramctrl_datactrl_data_data_out,
  input  logic                    inst_ramctrl_en_in,
  input  logic [AddressWidth-1:0] inst_ramctrl_addr_in,
  output logic                    ramctrl_inst_rdy_out,
  output logic [IDWidth-1:0]      ramctrl_inst_data_out,
  input  logic [7:0]              mem_din_in,
  output logic [7:0]              mem_dout_out,
  output logic [AddressWidth-1:0] mem_a_out,
  output logic                    mem_wr_out,
  input  logic                    io_buffer_full_in
);

  state_e                  state_q, state_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [2:0]              n_q, n_d;
  logic                    rw_q, rw_d;
  logic                    sgn_q, sgn_d;
  logic [IDWidth-1:0]      wdata_q, wdata_d;
  logic                    src_q, src_d;
  logic [2:0]              k_q, k_d;
  logic                    tagv_q, tagv_d;
  logic [1:0]              tag_q, tag_d;
  logic [IDWidth-1:0]      buf_q, buf_d;
  logic                    last_q, last_d;
  logic [AddressWidth-1:0] mema_q, mema_d;
  logic [7:0]              dout_q, dout_d;
  logic                    wr_q, wr_d;
  logic                    drdy_q, drdy_d;
  logic [IDWidth-1:0]      ddata_q, ddata_d;
  logic                    irdy_q, irdy_d;
  logic [IDWidth-1:0]      idata_q, idata_d;
  logic [IDWidth-1:0]      cap_word;
  logic [IDWidth-1:0]      ext_word;
  logic                    take_d, take_i;

  // The tag names the byte whose address was on the
  // bus last cycle, so din lands in the right lane
  // even when the address was held by a pause.
  always_comb begin
    cap_word = buf_q;
    if (state_q == S_READ && tagv_q) begin
      cap_word[{tag_q, 3'b000} +: 8] = mem_din_in;
    end
  end

  ramctrl_sext u_sext (
    .word_i (cap_word),
    .n_i    (n_q),
    .sgn_i  (sgn_q),
    .word_o (ext_word)
  );

  // Arbitration, byte issue and completion.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    n_d     = n_q;
    rw_d    = rw_q;
    sgn_d   = sgn_q;
    wdata_d = wdata_q;
    src_d   = src_q;
    k_d     = k_q;
    tagv_d  = tagv_q;
    tag_d   = tag_q;
    buf_d   = buf_q;
    last_d  = last_q;
    mema_d  = mema_q;
    dout_d  = dout_q;
    wr_d    = 1'b0;
    drdy_d  = 1'b0;
    ddata_d = ddata_q;
    irdy_d  = 1'b0;
    idata_d = idata_q;
    take_d  = 1'b0;
    take_i  = 1'b0;
    if (state_q == S_READ) begin
      buf_d  = cap_word;
      tagv_d = 1'b1;
      tag_d  = k_q[1:0];
    end
    if (rdy_in) begin
      unique case (state_q)
        S_IDLE: begin
          take_d = datactrl_ramctrl_data_en_in &&
                   (!inst_ramctrl_en_in || last_q);
          take_i = inst_ramctrl_en_in && !take_d;
          if (take_d || take_i) begin
            addr_d  = take_i ? inst_ramctrl_addr_in
                             : datactrl_ramctrl_data_addr_in;
            n_d     = take_i ? WIDTH_W
                             : width_n(datactrl_ramctrl_data_width_in);
            rw_d    = take_d && datactrl_ramctrl_data_rw_in;
            sgn_d   = take_d && datactrl_ramctrl_data_sgn_in;
            wdata_d = datactrl_ramctrl_data_data_in;
            src_d   = take_i;
            last_d  = take_i;
            k_d     = 3'd0;
            tagv_d  = 1'b0;
            tag_d   = 2'd0;
            buf_d   = '0;
            if (!rw_d) begin
              state_d = S_READ;
              mema_d  = addr_d;
            end else if (is_io(addr_d[17:16]) && io_buffer_full_in) begin
              state_d = S_IOSTALL;
            end else begin
              state_d = S_WRITE;
              wr_d    = 1'b1;
              mema_d  = addr_d;
              dout_d  = wdata_d[7:0];
              k_d     = 3'd1;
            end
          end
        end
        S_READ: begin
          if (tagv_q && {1'b0, tag_q} == n_q - 3'd1) begin
            state_d = S_IDLE;
            tagv_d  = 1'b0;
            if (src_q) begin
              irdy_d  = 1'b1;
              idata_d = cap_word;
            end else begin
              drdy_d  = 1'b1;
              ddata_d = ext_word;
            end
          end else if (k_q < n_q - 3'd1) begin
            k_d    = k_q + 3'd1;
            mema_d = addr_q + {{(AddressWidth-3){1'b0}}, k_d};
          end
        end
        S_WRITE, S_IOSTALL: begin
          if (k_q == n_q) begin
            state_d = S_IDLE;
            drdy_d  = 1'b1;
          end else if (is_io(addr_q[17:16]) && io_buffer_full_in) begin
            state_d = S_IOSTALL;
          end else begin
            state_d = S_WRITE;
            wr_d    = 1'b1;
            mema_d  = addr_q + {{(AddressWidth-3){1'b0}}, k_q};
            dout_d  = wdata_q[{k_q[1:0], 3'b000} +: 8];
            k_d     = k_q + 3'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and registered outputs; last_q starts on
  // the fetch port so data wins the first tie.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      n_q     <= 3'd0;
      rw_q    <= 1'b0;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      src_q   <= 1'b0;
      k_q     <= 3'd0;
      tagv_q  <= 1'b0;
      tag_q   <= 2'd0;
      buf_q   <= '0;
      last_q  <= 1'b1;
      mema_q  <= '0;
      dout_q  <= 8'd0;
      wr_q    <= 1'b0;
      drdy_q  <= 1'b0;
      ddata_q <= '0;
      irdy_q  <= 1'b0;
      idata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      n_q     <= n_d;
      rw_q    <= rw_d;
      sgn_q   <= sgn_d;
      wdata_q <= wdata_d;
      src_q   <= src_d;
      k_q     <= k_d;
      tagv_q  <= tagv_d;
      tag_q   <= tag_d;
      buf_q   <= buf_d;
      last_q  <= last_d;
      mema_q  <= mema_d;
      dout_q  <= dout_d;
      wr_q    <= wr_d;
      drdy_q  <= drdy_d;
      ddata_q <= ddata_d;
      irdy_q  <= irdy_d;
      idata_q <= idata_d;
    end
  end

  assign ramctrl_datactrl_data_rdy_out  = drdy_q;
  assign ramctrl_datactrl_data_data_out = ddata_q;
  assign ramctrl_inst_rdy_out           = irdy_q;
  assign ramctrl_inst_data_out          = idata_q;
  assign mem_dout_out                   = dout_q;
  assign mem_a_out                      = mema_q;
  assign mem_wr_out                     = wr_q;

endmodule

// File: tb/tb_ramctrl.sv
// Directed bench for ramctrl with a 1-cycle-latency
// byte RAM model and an I/O write counter.
module tb_ramctrl;
  import ramctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b1;
  logic        d_en = 1'b0;
  logic        d_rw = 1'b0;
  logic        d_sgn = 1'b0;
  logic [2:0]  d_w = 3'd4;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wd = '0;
  logic        drdy;
  logic [31:0] ddata;
  logic        i_en = 1'b0;
  logic [31:0] i_addr = '0;
  logic        irdy;
  logic [31:0] idata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        full = 1'b0;

  logic [7:0]  mem [0:4095];
  logic [31:0] a_log [0:63];
  logic        wr_log [0:63];
  logic [7:0]  d_log [0:63];
  int          io_wr_cnt = 0;
  logic [7:0]  io_last = 8'd0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_din <= mem[mem_a[11:0]];

  ramctrl dut (
    .clk_in                         (clk),
    .rst_in                         (rst_n),
    .rdy_in                         (run),
    .datactrl_ramctrl_data_en_in    (d_en),
    .datactrl_ramctrl_data_rw_in    (d_rw),
    .datactrl_ramctrl_data_sgn_in   (d_sgn),
    .datactrl_ramctrl_data_width_in (d_w),
    .datactrl_ramctrl_data_addr_in  (d_addr),
    .datactrl_ramctrl_data_data_in  (d_wd),
    .ramctrl_datactrl_data_rdy_out  (drdy),
    .ramctrl_datactrl_data_data_out (ddata),
    .inst_ramctrl_en_in             (i_en),
    .inst_ramctrl_addr_in           (i_addr),
    .ramctrl_inst_rdy_out           (irdy),
    .ramctrl_inst_data_out          (idata),
    .mem_din_in                     (mem_din),
    .mem_dout_out                   (mem_dout),
    .mem_a_out                      (mem_a),
    .mem_wr_out                     (mem_wr),
    .io_buffer_full_in              (full)
  );

  // Issues one request in cycle 0 and logs the bus in
  // cycles 1.. until the source port's rdy is seen.
  task automatic run_req(
    input  logic        inst,
    input  logic        rw,
    input  logic        sgn,
    input  logic [2:0]  w,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  int          ps,
    input  int          pl,
    input  int          fl,
    output int          rc,
    output logic [31:0] rd,
    output logic        after
  );
    rc = -1;
    rd = '0;
    for (int i = 0; i < 64; i++) begin
      a_log[i] = '0;
      wr_log[i] = 1'b0;
      d_log[i] = '0;
    end
    if (inst) begin
      i_en = 1'b1;
      i_addr = addr;
    end else begin
      d_en = 1'b1;
      d_rw = rw;
      d_sgn = sgn;
      d_w = w;
      d_addr = addr;
      d_wd = wd;
    end
    full = (fl > 0);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      run = !(c >= ps && c < ps + pl);
      full = (c < fl);
      a_log[c] = mem_a;
      wr_log[c] = mem_wr;
      d_log[c] = mem_dout;
      if (mem_wr) begin
        if (mem_a[17:16] == 2'b11) begin
          io_wr_cnt++;
          io_last = mem_dout;
        end else begin
          mem[mem_a[11:0]] = mem_dout;
        end
      end
      if (inst ? irdy : drdy) begin
        rc = c;
        rd = inst ? idata : ddata;
        d_en = 1'b0;
        i_en = 1'b0;
        break;
      end
    end
    d_en = 1'b0;
    i_en = 1'b0;
    @(posedge clk);
    #1;
    after = drdy | irdy;
    run = 1'b1;
    full = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({drdy, irdy, mem_wr} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=000",
               {drdy, irdy, mem_wr});
    end
    checks++;
    if (mem_a !== 32'h0) begin
      failures++;
      $display("FAIL reset_addr got=%h exp=0", mem_a);
    end
    checks++;
    if ({ddata, idata, mem_dout} !== 72'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0",
               {ddata, idata, mem_dout});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_tie();
    int dc = -1;
    int ic = -1;
    logic [31:0] dd = '0;
    logic [31:0] id = '0;
    d_en = 1'b1;
    d_rw = 1'b0;
    d_sgn = 1'b0;
    d_w = 3'd4;
    d_addr = 32'h100;
    i_en = 1'b1;
    i_addr = 32'h0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (drdy) begin
        dc = c;
        dd = ddata;
        d_en = 1'b0;
      end
      if (irdy) begin
        ic = c;
        id = idata;
        i_en = 1'b0;
        break;
      end
    end
    d_en = 1'b0;
    i_en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (dc !== 6) begin
      failures++;
      $display("FAIL tie_data_cycle got=%0d exp=6", dc);
    end
    checks++;
    if (dd !== 32'h1234_5678) begin
      failures++;
      $display("FAIL tie_data got=%h exp=12345678", dd);
    end
    checks++;
    if (ic !== 12) begin
      failures++;
      $display("FAIL tie_fetch_cycle got=%0d exp=12", ic);
    end
    checks++;
    if (id !== 32'h0000_0013) begin
      failures++;
      $display("FAIL tie_fetch got=%h exp=00000013", id);
    end
  endtask

  task automatic test_read_word();
    int rc;
    logic [31:0] rd;
    logic after;
    run_req(1'b0, 1'b0, 1'b0, 3'd4, 32'h100, 32'h0,
            0, 0, 0, rc, rd, after);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (a_log[k+1] !== 32'h100 + k || wr_log[k+1] !== 1'b0) begin
        failures++;
        $display("FAIL rw_addr%0d got=%h/%b exp=%h/0", k,
                 a_log[k+1], wr_log[k+1], 32'h100 + k);
      end
    end
    checks++;
    if (rc !== 6) begin
      failures++;
      $display("FAIL rw_cycle got=%0d exp=6", rc);
    end
    checks++;
    if (rd !== 32'h1234_5678) begin
      failures++;
      $display("FAIL rw_data got=%h exp=12345678", rd);
    end
    checks++;
    if (after !== 1'b0) begin
      failures++;
      $display("FAIL rw_pulse got=%b exp=0", after);
    end
  endtask

  task automatic test_sbyte();
    int rc;
    logic [31:0] rd;
    logic after;
    run_req(1'b0, 1'b0, 1'b1, 3'd1, 32'h200, 32'h0,
            0, 0, 0, rc, rd, after);
    checks++;
    if (rd !== 32'hFFFF_FF80 || rc !== 3) begin
      failures++;
      $display("FAIL sbyte_sx got=%h@%0d exp=ffffff80@3", rd, rc);
    end
    run_req(1'b0, 1'b0, 1'b0, 3'd1, 32'h200, 32'h0,
            0, 0, 0, rc, rd, after);
    checks++;
    if (rd !== 32'h0000_0080) begin
      failures++;
      $display("FAIL sbyte_zx got=%h exp=00000080", rd);
    end
    run_req(1'b0, 1'b0, 1'b1, 3'd2, 32'h202, 32'h0,
            0, 0, 0, rc, rd, after);
    checks++;
    if (rd !== 32'hFFFF_9A01 || rc !== 4) begin
      failures++;
      $display("FAIL shalf_sx got=%h@%0d exp=ffff9a01@4", rd, rc);
    end
  endtask

  task automatic test_half_write();
    int rc;
    logic [31:0] rd;
    logic after;
    run_req(1'b0, 1'b1, 1'b0, 3'd2, 32'h300, 32'hDEAD_BEEF,
            0, 0, 0, rc, rd, after);
    checks++;
    if ({wr_log[1], a_log[1], d_log[1]} !== {1'b1, 32'h300, 8'hEF}) begin
      failures++;
      $display("FAIL hw_b0 got=%b/%h/%h exp=1/300/ef",
               wr_log[1], a_log[1], d_log[1]);
    end
    checks++;
    if ({wr_log[2], a_log[2], d_log[2]} !== {1'b1, 32'h301, 8'hBE}) begin
      failures++;
      $display("FAIL hw_b1 got=%b/%h/%h exp=1/301/be",
               wr_log[2], a_log[2], d_log[2]);
    end
    checks++;
    if (rc !== 3 || wr_log[3] !== 1'b0) begin
      failures++;
      $display("FAIL hw_rdy got=%0d/%b exp=3/0", rc, wr_log[3]);
    end
    checks++;
    if ({mem[12'h300], mem[12'h301], mem[12'h302], mem[12'h303]}
        !== 32'hEFBE_3344) begin
      failures++;
      $display("FAIL hw_mem got=%h exp=efbe3344",
               {mem[12'h300], mem[12'h301], mem[12'h302], mem[12'h303]});
    end
  endtask

  task automatic test_io_stall();
    int rc;
    logic [31:0] rd;
    logic after;
    io_wr_cnt = 0;
    run_req(1'b0, 1'b1, 1'b0, 3'd1, 32'h3_0000, 32'h0000_005A,
            0, 0, 3, rc, rd, after);
    checks++;
    if ((wr_log[1] | wr_log[2] | wr_log[3]) !== 1'b0) begin
      failures++;
      $display("FAIL io_hold got=%b%b%b exp=000",
               wr_log[1], wr_log[2], wr_log[3]);
    end
    checks++;
    if ({wr_log[4], a_log[4], d_log[4]} !== {1'b1, 32'h3_0000, 8'h5A}) begin
      failures++;
      $display("FAIL io_write got=%b/%h/%h exp=1/30000/5a",
               wr_log[4], a_log[4], d_log[4]);
    end
    checks++;
    if (rc !== 5 || io_wr_cnt !== 1) begin
      failures++;
      $display("FAIL io_rdy got=%0d/%0d exp=5/1", rc, io_wr_cnt);
    end
  endtask

  task automatic test_pause();
    int rc;
    logic [31:0] rd;
    logic after;
    run_req(1'b0, 1'b0, 1'b0, 3'd4, 32'h100, 32'h0,
            2, 2, 0, rc, rd, after);
    checks++;
    if (rc !== 8) begin
      failures++;
      $display("FAIL pause_cycle got=%0d exp=8", rc);
    end
    checks++;
    if (rd !== 32'h1234_5678) begin
      failures++;
      $display("FAIL pause_data got=%h exp=12345678", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    d_en = 1'b1;
    d_rw = 1'b1;
    d_w = 3'd4;
    d_addr = 32'h310;
    d_wd = 32'hCAFE_F00D;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (mem_wr !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre got=%b exp=1", mem_wr);
    end
    rst_n = 1'b0;
    d_en = 1'b0;
    #1;
    checks++;
    if ({drdy, irdy, mem_wr, mem_a, mem_dout} !== 43'h0) begin
      failures++;
      $display("FAIL rst_async got=%h exp=0",
               {drdy, irdy, mem_wr, mem_a, mem_dout});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      seen = seen | drdy | irdy | mem_wr;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL rst_abandon got=%b exp=0", seen);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'h78;
    mem[12'h101] = 8'h56;
    mem[12'h102] = 8'h34;
    mem[12'h103] = 8'h12;
    mem[12'h200] = 8'h80;
    mem[12'h202] = 8'h01;
    mem[12'h203] = 8'h9A;
    mem[12'h300] = 8'h11;
    mem[12'h301] = 8'h22;
    mem[12'h302] = 8'h33;
    mem[12'h303] = 8'h44;
    mem[12'h000] = 8'h13;
    test_reset();
    test_tie();
    test_read_word();
    test_sbyte();
    test_half_write();
    test_io_stall();
    test_pause();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ramctrl.md
Name: ramctrl

Overview:
- Responder end of the data-port request/ready protocol, plus an instruction-fetch port.
- Accepts load/store requests of 1, 2 or 4 bytes and 4-byte instruction fetches.
- Serialises each request into byte accesses on the single 8-bit RAM/IO bus, assembles and extends read data, and returns a one-cycle ready pulse.
- Sits between the data/instruction controllers and the top-level memory pins.

Parameters:
AddressWidth, 32, address width in bits
IDWidth, 32, data word width in bits
IOBase, 32'h00030000, addresses with addr[17:16]==2'b11 are I/O

Ports:
clk_in  input  1  clock
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global enable; low = pause
datactrl_ramctrl_data_en_in  input  1  data request, level-held until ready
datactrl_ramctrl_data_rw_in  input  1  1=write, 0=read
datactrl_ramctrl_data_sgn_in  input  1  read: 1=sign-extend, 0=zero-extend
datactrl_ramctrl_data_width_in  input  3  byte count: 1, 2 or 4; other values are treated as 4
datactrl_ramctrl_data_addr_in  input  AddressWidth  byte address
datactrl_ramctrl_data_data_in  input  IDWidth  write data, low bytes used
ramctrl_datactrl_data_rdy_out  output  1  one-cycle completion pulse
ramctrl_datactrl_data_data_out  output  IDWidth  extended read data, valid with rdy
inst_ramctrl_en_in  input  1  fetch request, level-held
inst_ramctrl_addr_in  input  AddressWidth  fetch address
ramctrl_inst_rdy_out  output  1  one-cycle fetch completion pulse
ramctrl_inst_data_out  output  IDWidth  fetched word, valid with rdy
mem_din_in  input  8  RAM/IO read byte
mem_dout_out  output  8  RAM/IO write byte
mem_a_out  output  AddressWidth  RAM/IO byte address
mem_wr_out  output  1  1=write this cycle
io_buffer_full_in  input  1  I/O write buffer full

Behaviour:
- Reset (rst_in low, any time): state IDLE. All outputs 0, including both rdy pulses, mem_wr_out and mem_a_out. Any in-flight transaction is abandoned with no rdy.
- States: IDLE, READ, WRITE, IOSTALL. All outputs are registered.
- IDLE accepts at most one request per cycle (cycle A).
- Arbitration in IDLE:
  - Only one port requesting: that port wins.
  - Both requesting: the port not served last wins.
  - last_served resets to instruction, so the data port wins the first tie.
- Accepted request latches addr, N (byte count; fetch N=4), rw, sgn, wdata and source. Byte index k is cleared to 0.
- READ:
  - Cycles A+1..A+N drive mem_a_out = addr+k, k = 0..N-1, with mem_wr_out=0.
  - RAM read latency is 1 cycle: byte k is on mem_din_in in cycle A+2+k and is stored little-endian at bits [8k+7:8k].
  - rdy for the source port is high for exactly cycle A+N+2, with data.
  - Return to IDLE in that same cycle; a new request can be accepted in cycle A+N+2 at the earliest.
- Extension on data reads:
  - N=1: bits [31:8] = sgn ? bit7 : 0.
  - N=2: bits [31:16] = sgn ? bit15 : 0.
  - N=4: no extension.
  - Fetch: no extension.
- WRITE:
  - Cycles A+1..A+N drive mem_wr_out=1, mem_a_out=addr+k and mem_dout_out = wdata[8k+7:8k].
  - rdy is high in cycle A+N+1, then return to IDLE.
- IOSTALL (I/O write while io_buffer_full_in=1):
  - Entered before issuing the current byte; mem_wr_out=0, k holds.
  - Each byte issue checks io_buffer_full_in. Byte k is issued in the first cycle io_buffer_full_in is 0.
  - Reads never stall on io_buffer_full_in.
- rdy_in low (pause):
  - FSM, k and captured bytes hold.
  - mem_a_out holds its last value and mem_wr_out is forced 0.
  - The write byte due in a paused cycle is issued in the first cycle after resume.
  - For reads, the in-flight byte is re-captured on resume because the address was held.
  - A rdy pulse that falls into a paused cycle is deferred to the first running cycle.
- Requester contract: en deasserts in the cycle rdy is seen. An en still high in the cycle after rdy is a new request.
- Address arithmetic wraps modulo 2^AddressWidth.

Decomposition:
- Shared package holds:
  - AddressWidth, IDWidth and IOBase.
  - Width encodings WIDTH_B=3'd1, WIDTH_H=3'd2, WIDTH_W=3'd4.
  - The ramctrl state enum.
- One combinational sub-module, ramctrl_sext: inputs assembled word, N and sgn; output is the extended word.

Test Plan:
- Data read word: memory 0x100..0x103 = 78 56 34 12, req rw=0, width=4, addr=0x100 accepted at A -> mem_a_out 0x100..0x103 in A+1..A+4; rdy in A+6 only; data 0x12345678.
- Signed byte read: memory 0x200 = 0x80. sgn=1, width=1 -> data 0xFFFFFF80. sgn=0 -> data 0x00000080.
- Half write: wdata=0xDEADBEEF, width=2, addr=0x300 -> (0x300,EF) and (0x301,BE) with mem_wr_out=1 in A+1, A+2; rdy in A+3; bytes 0x302/0x303 unchanged.
- Tie arbitration: data and fetch both asserted after reset -> data served first, fetch accepted next. Fetch of 0x0 returns 0x00000013 when memory 0x0..0x3 = 13 00 00 00.
- I/O stall: write width=1, addr=0x30000 with io_buffer_full_in=1 for 3 cycles -> no mem_wr_out while full; single write when it drops; rdy one cycle after that write.
- Pause and reset: rdy_in low 2 cycles mid word read -> same result, rdy delayed 2 cycles. rst_in low mid-write -> all outputs 0 immediately; no rdy after release.
